bus_access_ctrl: RTL

//  Sequences one bus transaction at a time between the current bus owner and
//  up to 8 slaves: latches the address phase, decodes the slave, drives the

---
 rtl/bus_access_ctrl_pkg.sv | 30 +++
 rtl/bus_addr_dec.sv | 36 +++
 rtl/bus_access_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bus_access_ctrl_pkg.sv
// Shared definitions for the bus access controller.
//   - FSM state encoding
//   - slave index width and per-slave index constants
//   - read/write encodings of the rw signal
package bus_access_ctrl_pkg;

    localparam int unsigned BUS_SLAVE_IDX_W = 3;

    typedef logic [BUS_SLAVE_IDX_W-1:0] slave_idx_t;

    localparam slave_idx_t SLAVE_0 = 3'd0;
    localparam slave_idx_t SLAVE_1 = 3'd1;
    localparam slave_idx_t SLAVE_2 = 3'd2;
    localparam slave_idx_t SLAVE_3 = 3'd3;
    localparam slave_idx_t SLAVE_4 = 3'd4;
    localparam slave_idx_t SLAVE_5 = 3'd5;
    localparam slave_idx_t SLAVE_6 = 3'd6;
    localparam slave_idx_t SLAVE_7 = 3'd7;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } bus_state_e;

endpackage

// File: rtl/bus_addr_dec.sv
// Combinational slave decoder.
// Ports:
//   addr_i      master word address; slave index is the top BUS_SLAVE_IDX_W bits
//   idx_o       decoded slave index
//   unmapped_o  1 when idx_o >= NUM_SLAVES
//   cs_n_o      one-hot-low chip select pattern for idx_o (all 1 if unmapped)
module bus_addr_dec
    import bus_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned NUM_SLAVES = 8
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output slave_idx_t            idx_o,
    output logic                  unmapped_o,
    output logic [NUM_SLAVES-1:0] cs_n_o
);

    // One extra bit so NUM_SLAVES = 8 is representable.
    localparam logic [BUS_SLAVE_IDX_W:0] NumSlavesW = (BUS_SLAVE_IDX_W + 1)'(NUM_SLAVES);

    // Only the top bits select the slave.
    logic unused_addr_low;
    assign unused_addr_low = ^addr_i[ADDR_W-BUS_SLAVE_IDX_W-1:0];

    assign idx_o      = addr_i[ADDR_W-1 -: BUS_SLAVE_IDX_W];
    assign unmapped_o = ({1'b0, idx_o} >= NumSlavesW);

    always_comb begin
        cs_n_o = '1;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_o == slave_idx_t'(i)) cs_n_o[i] = 1'b0;
        end
    end

endmodule

// File: rtl/bus_access_ctrl.sv
// Single-transaction bus sequencer between the current bus owner and up to 8 slaves.
// Latches the address phase, strobes the decoded slave, waits for its ready and
// returns read data / error to the master. All outputs are registered.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   m_as_, m_rw, m_addr,        master request (strobe active-low, 1 = read)
//   m_wr_data
//   m_rd_data, m_rdy_, m_err    master response, valid while m_rdy_ = 0
//   m_busy                      high whenever the FSM is not idle
//   s_cs_, s_as_, s_rw,         slave-side request (cs one-hot-low, as 1-cycle pulse)
//   s_addr, s_wr_data
//   s_rd_data, s_rdy_           slave responses, slave i at [i*DATA_W +: DATA_W]
// Build option: define BUS_TIMEOUT_EN to abort after TIMEOUT_CYC cycles without ready.
module bus_access_ctrl
    import bus_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_SLAVES  = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_as_,
    input  logic                         m_rw,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wr_data,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_rdy_,
    output logic                         m_err,
    output logic                         m_busy,
    output logic [NUM_SLAVES-1:0]        s_cs_,
    output logic                         s_as_,
    output logic                         s_rw,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wr_data,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    input  logic [NUM_SLAVES-1:0]        s_rdy_
);

    bus_state_e               state_q;
    slave_idx_t               idx_q;
    logic [DATA_W-1:0]        m_rd_data_q;
    logic                     m_rdy_q, m_err_q, m_busy_q;
    logic [NUM_SLAVES-1:0]    s_cs_q;
    logic                     s_as_q, s_rw_q;
    logic [ADDR_W-1:0]        s_addr_q;
    logic [DATA_W-1:0]        s_wr_data_q;

    slave_idx_t               dec_idx;
    logic                     dec_unmapped;
    logic [NUM_SLAVES-1:0]    dec_cs_n;

    logic                     sel_rdy_n;
    logic [DATA_W-1:0]        sel_rd_data;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    bus_addr_dec #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_dec (
        .addr_i     (m_addr),
        .idx_o      (dec_idx),
        .unmapped_o (dec_unmapped),
        .cs_n_o     (dec_cs_n)
    );

    // Ready/data of the latched slave only; other slaves' ready is ignored.
    always_comb begin
        sel_rdy_n   = 1'b1;
        sel_rd_data = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_q == slave_idx_t'(i)) begin
                sel_rdy_n   = s_rdy_[i];
                sel_rd_data = s_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            m_rd_data_q <= '0;
            m_rdy_q     <= 1'b1;
            m_err_q     <= 1'b0;
            m_busy_q    <= 1'b0;
            s_cs_q      <= '1;
            s_as_q      <= 1'b1;
            s_rw_q      <= 1'b1;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!m_as_) begin
                        s_addr_q    <= m_addr;
                        s_rw_q      <= m_rw;
                        s_wr_data_q <= m_wr_data;
                        idx_q       <= dec_idx;
                        m_busy_q    <= 1'b1;
                        if (dec_unmapped) begin
                            // Answer straight away without touching any slave.
                            state_q     <= StResp;
                            m_rdy_q     <= 1'b0;
                            m_err_q     <= 1'b1;
                            m_rd_data_q <= '0;
                        end else begin
                            state_q <= StAccess;
                            s_cs_q  <= dec_cs_n;
                            s_as_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                StAccess, StWait: begin
                    s_as_q <= 1'b1;
                    // Ready wins over a coincident timeout expiry.
                    if (!sel_rdy_n) begin
                        state_q     <= StResp;
                        s_cs_q      <= '1;
                        m_rdy_q     <= 1'b0;
                        m_err_q     <= 1'b0;
                        m_rd_data_q <= (s_rw_q == BUS_READ) ? sel_rd_data : '0;
`ifdef BUS_TIMEOUT_EN
                    end else if (tmo_cnt_q == TimeoutLast) begin
                        state_q     <= StResp;
                        s_cs_q      <= '1;
                        m_rdy_q     <= 1'b0;
                        m_err_q     <= 1'b1;
                        m_rd_data_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        state_q   <= StWait;
                    end
`else
                    end else begin
                        state_q <= StWait;
                    end
`endif
                end
                StResp: begin
                    state_q  <= StIdle;
                    m_rdy_q  <= 1'b1;
                    m_err_q  <= 1'b0;
                    m_busy_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_rd_data = m_rd_data_q;
    assign m_rdy_    = m_rdy_q;
    assign m_err     = m_err_q;
    assign m_busy    = m_busy_q;
    assign s_cs_     = s_cs_q;
    assign s_as_     = s_as_q;
    assign s_rw      = s_rw_q;
    assign s_addr    = s_addr_q;
    assign s_wr_data = s_wr_data_q;

endmodule
